// File: rtl/fifo_sync_pkg.sv
// ---------------------------------------------------------------------------
// fifo_sync_pkg
//
// Purpose:
//   Shared definitions for the parametrised synchronous FIFO. This package
//   holds the following items:
//     - calcCountWidth : width of the occupancy counter for a given depth.
//       The counter must represent 0..DEPTH inclusive, so it needs one bit
//       more than the pointers.
//     - isPowerOfTwo   : used by the top level to reject illegal depths at
//       elaboration time.
//     - thresholdsLegal: range check for the almost-full/almost-empty levels.
//     - fifoOp_t       : the kind of access accepted on a clock edge. It
//       drives the count update.
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package fifo_sync_pkg;

    // The kind of access that was accepted on this edge.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifoOp_t;

    // Number of bits needed to hold an occupancy of 0..depth.
    function automatic int calcCountWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // True when value is a positive power of two.
    function automatic bit isPowerOfTwo(input int value);
        return (value >= 1) && ((value & (value - 1)) == 0);
    endfunction

    // almost_full must be reachable and non-trivial (1..depth).
    // almost_empty must leave room below full (0..depth-1).
    function automatic bit thresholdsLegal(input int depth,
                                           input int afLevel,
                                           input int aeLevel);
        return (afLevel >= 1) && (afLevel <= depth) &&
               (aeLevel >= 0) && (aeLevel <= depth - 1);
    endfunction

endpackage : fifo_sync_pkg

// File: rtl/fifo_sync_ram.sv
// ---------------------------------------------------------------------------
// fifo_sync_ram
//
// Purpose:
//   This is the DEPTH x WIDTH storage array of the FIFO. It has one write port
//   and one synchronous read port. The array itself is never reset, so a
//   synthesis tool can map it to block or distributed RAM. Only the read
//   data register is cleared by reset. A read and a write to the same
//   address on the same edge return the old contents (read-before-write).
//   The FIFO relies on this when it is full and both reads and writes.
//
// Ports:
//   clk       in  clock, rising edge
//   rst       in  synchronous active-high reset, clears o_rdData only
//   i_wrEn    in  write strobe
//   i_wrAddr  in  write address
//   i_wrData  in  write data
//   i_rdEn    in  read strobe. When low, o_rdData holds its value.
//   i_rdAddr  in  read address
//   o_rdData  out registered read data
// ---------------------------------------------------------------------------
module fifo_sync_ram #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wrEn,
    input  logic [AW-1:0]    i_wrAddr,
    input  logic [WIDTH-1:0] i_wrData,
    input  logic             i_rdEn,
    input  logic [AW-1:0]    i_rdAddr,
    output logic [WIDTH-1:0] o_rdData
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdData;

    // Storage array. This block has no reset, so the array can map onto
    // RAM primitives.
    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    // Read data register. Reset gives a defined output word after power-up.
    // When no read is requested, the last word stays on the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdData <= '0;
        end else if (i_rdEn) begin
            r_rdData <= r_mem[i_rdAddr];
        end
    end

    assign o_rdData = r_rdData;

endmodule : fifo_sync_ram

// File: rtl/fifo_sync_param.sv
// ---------------------------------------------------------------------------
// fifo_sync_param
//
// Purpose:
//   This is a parametrised single-clock FIFO. It has the following features:
//     - registered read data with a one-cycle valid pulse
//     - an occupancy count
//     - programmable almost-full and almost-empty flags
//     - sticky overflow and underflow error flags
//     - a synchronous flush
//   Storage lives in fifo_sync_ram. This level owns the pointers, the count,
//   the status flags and valid.
//
// Parameters:
//   WIDTH     data word width (>= 1)
//   DEPTH     number of entries (power of two, >= 2)
//   AF_LEVEL  almost_full when count >= AF_LEVEL  (1..DEPTH)
//   AE_LEVEL  almost_empty when count <= AE_LEVEL (0..DEPTH-1)
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   clr           in   synchronous flush (data_out is kept)
//   data_in       in   write data
//   w_en          in   write request
//   r_en          in   read request
//   data_out      out  registered read data
//   valid         out  data_out holds a word read on the last edge
//   empty         out  count == 0
//   full          out  count == DEPTH
//   almost_empty  out  count <= AE_LEVEL
//   almost_full   out  count >= AF_LEVEL
//   count         out  occupancy 0..DEPTH
//   overflow      out  sticky: a write was rejected
//   underflow     out  sticky: a read was rejected
// ---------------------------------------------------------------------------
module fifo_sync_param
    import fifo_sync_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int DEPTH    = 8,
    parameter  int AF_LEVEL = DEPTH - 1,
    parameter  int AE_LEVEL = 1,
    localparam int CW       = calcCountWidth(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             w_en,
    input  logic             r_en,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    // Elaboration-time legality checks. An illegal configuration stops the
    // build instead of producing a FIFO that misbehaves quietly.
    generate
        if (WIDTH < 1) begin : g_badWidth
            $error("fifo_sync_param: WIDTH must be at least 1");
        end
        if (!isPowerOfTwo(DEPTH) || (DEPTH < 2)) begin : g_badDepth
            $error("fifo_sync_param: DEPTH must be a power of two and at least 2");
        end
        if (!thresholdsLegal(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_badLevels
            $error("fifo_sync_param: AF_LEVEL must be 1..DEPTH and AE_LEVEL 0..DEPTH-1");
        end
    endgenerate

    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic          r_valid;
    logic          r_empty;
    logic          r_full;
    logic          r_almostEmpty;
    logic          r_almostFull;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_flush;
    logic          w_rdOk;
    logic          w_wrOk;
    logic          w_wrReject;
    logic          w_rdReject;
    fifoOp_t       w_op;
    logic [CW-1:0] w_countNext;
    logic [WIDTH-1:0] w_rdData;

    // Reset and flush both discard any access requested in the same cycle.
    // Gating the accept terms with w_flush means the RAM and the pointers
    // cannot see a stray write or read while a flush happens.
    assign w_flush = rst | clr;

    // A read needs data to be present. A write needs room, unless a read
    // frees a slot on the same edge. When the FIFO is empty, a simultaneous
    // read is still rejected because there is no write-through path.
    assign w_rdOk     = ~w_flush & r_en & ~r_empty;
    assign w_wrOk     = ~w_flush & w_en & (~r_full | r_en);
    assign w_wrReject = ~w_flush & w_en & ~w_wrOk;
    assign w_rdReject = ~w_flush & r_en & r_empty;

    // Classify the accepted access and derive the next occupancy. Read and
    // write together leave the count unchanged. The flags below are
    // computed from this value, so they match the count after the edge.
    always_comb begin
        w_op        = OP_IDLE;
        w_countNext = r_count;
        case ({w_wrOk, w_rdOk})
            2'b10:   w_op = OP_WRITE;
            2'b01:   w_op = OP_READ;
            2'b11:   w_op = OP_BOTH;
            default: w_op = OP_IDLE;
        endcase
        case (w_op)
            OP_WRITE: w_countNext = r_count + CW'(1);
            OP_READ:  w_countNext = r_count - CW'(1);
            default:  w_countNext = r_count;
        endcase
    end

    // Pointers, count, valid and the status flags. Reset and flush clear
    // the same state here. The only difference between them is data_out,
    // which lives in the RAM's read register and is cleared by rst alone.
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
            r_count       <= '0;
            r_valid       <= 1'b0;
            r_empty       <= 1'b1;
            r_full        <= 1'b0;
            r_almostEmpty <= 1'b1;
            r_almostFull  <= (AF_LEVEL == 0);
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            if (w_wrOk) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_rdOk) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            r_count       <= w_countNext;
            r_valid       <= w_rdOk;
            r_empty       <= (w_countNext == '0);
            r_full        <= (w_countNext == DEPTH_C);
            r_almostEmpty <= (w_countNext <= AE_C);
            r_almostFull  <= (w_countNext >= AF_C);
            r_overflow    <= r_overflow | w_wrReject;
            r_underflow   <= r_underflow | w_rdReject;
        end
    end

    // Storage. The read port register supplies data_out directly.
    fifo_sync_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .i_wrEn   (w_wrOk),
        .i_wrAddr (r_wrPtr),
        .i_wrData (data_in),
        .i_rdEn   (w_rdOk),
        .i_rdAddr (r_rdPtr),
        .o_rdData (w_rdData)
    );

    assign data_out     = w_rdData;
    assign valid        = r_valid;
    assign empty        = r_empty;
    assign full         = r_full;
    assign almost_empty = r_almostEmpty;
    assign almost_full  = r_almostFull;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule : fifo_sync_param

// File: tb/tb_fifo_sync_param.sv
// ---------------------------------------------------------------------------
// tb_fifo_sync_param
//
// Purpose:
//   Directed testbench for fifo_sync_param with WIDTH=8, DEPTH=8,
//   AF_LEVEL=7 and AE_LEVEL=1. Every expected value below is worked out by
//   hand from the FIFO's intended behaviour.
// ---------------------------------------------------------------------------
module tb_fifo_sync_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic [WIDTH-1:0] data_in;
    logic             w_en;
    logic             r_en;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    int checkCount = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    fifo_sync_param #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (7),
        .AE_LEVEL (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .data_in      (data_in),
        .w_en         (w_en),
        .r_en         (r_en),
        .data_out     (data_out),
        .valid        (valid),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Compares one observed value with the hand-computed expectation.
    // Every check goes through this task.
    task automatic checkOutput(input string tag,
                               input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, waits for the rising edge, and then
    // settles 1 time unit past it, where the outputs can be sampled.
    task automatic applyStimulus(input logic iRst, input logic iClr,
                                 input logic iWen, input logic iRen,
                                 input logic [WIDTH-1:0] iData);
        rst     = iRst;
        clr     = iClr;
        w_en    = iWen;
        r_en    = iRen;
        data_in = iData;
        @(posedge clk);
        #1;
    endtask

    // Status flags for a given occupancy with AF_LEVEL=7 and AE_LEVEL=1,
    // plus the two sticky error flags.
    task automatic checkFlags(input string tag, input int expCount,
                              input logic expOvf, input logic expUdf);
        checkOutput({tag, ".count"}, 32'(count), 32'(expCount));
        checkOutput({tag, ".empty"}, 32'(empty), 32'(expCount == 0));
        checkOutput({tag, ".full"}, 32'(full), 32'(expCount == 8));
        checkOutput({tag, ".almost_empty"}, 32'(almost_empty), 32'(expCount <= 1));
        checkOutput({tag, ".almost_full"}, 32'(almost_full), 32'(expCount >= 7));
        checkOutput({tag, ".overflow"}, 32'(overflow), 32'(expOvf));
        checkOutput({tag, ".underflow"}, 32'(underflow), 32'(expUdf));
    endtask

    initial begin
        // Reset hold: w_en and r_en are high throughout and must be ignored.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
        end
        checkOutput("reset.data_out", 32'(data_out), 32'h0);
        checkOutput("reset.valid", 32'(valid), 32'h0);
        checkFlags("reset", 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkFlags("idle", 0, 1'b0, 1'b0);

        // Fill with 0x00..0x07, then drain in order.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'(i));
            checkOutput("fill.valid", 32'(valid), 32'h0);
            checkFlags("fill", i + 1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
            checkOutput("drain.valid", 32'(valid), 32'h1);
            checkOutput("drain.data", 32'(data_out), 32'(i));
            checkFlags("drain", 7 - i, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("hold.valid", 32'(valid), 32'h0);
        checkOutput("hold.data", 32'(data_out), 32'h07);

        // Overflow: a write-only request while full is rejected.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'hAA);
        checkOutput("ovf.valid", 32'(valid), 32'h0);
        checkFlags("ovf", 8, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
            checkOutput("ovfdrain.data", 32'(data_out), 32'(8'h10 + i));
            checkFlags("ovfdrain", 7 - i, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checkFlags("ovfclr", 0, 1'b0, 1'b0);

        // Underflow: read and write together while empty accept only the write.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h55);
        checkOutput("udf.valid", 32'(valid), 32'h0);
        checkFlags("udf", 1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("udfread.valid", 32'(valid), 32'h1);
        checkOutput("udfread.data", 32'(data_out), 32'h55);
        checkFlags("udfread", 0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checkFlags("udfclr", 0, 1'b0, 1'b0);

        // Full read+write for 20 cycles: the count stays at 8, the first
        // 8 reads return 0x20..0x27, and the following reads return 0x30
        // onwards.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
        end
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'(8'h30 + k));
            checkOutput("rw.valid", 32'(valid), 32'h1);
            checkOutput("rw.data", 32'(data_out),
                        (k < 8) ? 32'(8'h20 + k) : 32'(8'h30 + k - 8));
            checkFlags("rw", 8, 1'b0, 1'b0);
        end
        // The words left over are the last 8 written: 0x3C..0x43.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
            checkOutput("rwdrain.data", 32'(data_out), 32'(8'h3C + i));
            checkFlags("rwdrain", 7 - i, 1'b0, 1'b0);
        end

        // Flush mid-stream at count 5 with overflow set. A clr with r_en
        // high must not read, and it must leave data_out unchanged.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'hAA);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        end
        checkOutput("preflush.data", 32'(data_out), 32'h42);
        checkFlags("preflush", 5, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        checkOutput("flush.valid", 32'(valid), 32'h0);
        checkOutput("flush.data", 32'(data_out), 32'h42);
        checkFlags("flush", 0, 1'b0, 1'b0);

        // A write during clr is ignored, while reset clears data_out.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h77);
        checkFlags("clrwrite", 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h99);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("prerst.data", 32'(data_out), 32'h99);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("rst.data", 32'(data_out), 32'h0);
        checkFlags("rst", 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule : tb_fifo_sync_param
